vfu_mem_responder: RTL

//  Memory-side responder for the vector processor's memory port inside the Vfu.

---
 rtl/vfu_mem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vfu_mem_responder.sv
// Memory-side responder for the Vfu memory port: a word scratchpad with a
// fixed-latency read pipeline feeding an in-order valid/ready response FIFO.
module vfu_mem_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 512,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic                  rd_req_in,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  output logic                  req_ready_out,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  input  logic                  rd_ready_in,
  output logic                  err_out
);

  localparam int OFF_W  = 3;
  localparam int WORD_W = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W+1)'(RSP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RSP_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_FIFO_DEPTH];

  logic [WORD_W-1:0]     req_word;
  logic                  req_oor;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  unused_addr_bits;

  logic                  s1_valid;
  logic [WORD_W-1:0]     s1_word;
  logic                  s1_oor;
  logic                  s1_fwd;
  logic [DATA_WIDTH-1:0] s1_fwd_data;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [1:0]            inflight;
  logic [CNT_W:0]        occupancy;
  logic                  push;
  logic                  pop;

  assign req_word         = req_addr_in[OFF_W +: WORD_W];
  assign req_oor          = |req_addr_in[ADDR_WIDTH-1:OFF_W+WORD_W];
  assign unused_addr_bits = &{1'b0, req_addr_in[OFF_W-1:0]};

  // Every accepted read holds a slot from acceptance until it is popped, so
  // the FIFO can never be pushed while full.
  assign inflight      = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign occupancy     = {1'b0, fifo_count} + {{(CNT_W-1){1'b0}}, inflight};
  assign req_ready_out = ~reset & (occupancy < OCC_LIMIT);

  assign accept    = (rd_req_in | wr_en_in) & req_ready_out;
  assign rd_accept = rd_req_in & req_ready_out;
  assign wr_accept = wr_en_in & req_ready_out;

  assign push = s2_valid;
  assign pop  = (fifo_count != '0) & rd_ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= rd_accept;
      s2_valid <= s1_valid;
    end
  end

  // A write sharing the read's cycle always targets the same word, so its data
  // is carried alongside the read instead of relying on the RAM.
  always_ff @(posedge clk) begin
    s1_word     <= req_word;
    s1_oor      <= req_oor;
    s1_fwd      <= wr_accept & ~req_oor;
    s1_fwd_data <= wr_data_in;
  end

  always_ff @(posedge clk) begin
    if (wr_accept && !req_oor) begin
      mem[req_word] <= wr_data_in;
    end
    if (s1_oor) begin
      s2_data <= '0;
    end else if (s1_fwd) begin
      s2_data <= s1_fwd_data;
    end else begin
      s2_data <= mem[s1_word];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_out <= 1'b0;
    end else if (accept && req_oor) begin
      err_out <= 1'b1;
    end
  end

  assign rd_valid_out = (fifo_count != '0);
  assign rd_data_out  = rd_valid_out ? fifo_mem[rd_ptr] : '0;

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_count == FIFO_FULL)));

endmodule
